// File: rtl/key_pio_irq.sv
// key_pio_irq: Avalon-MM input PIO for active-low push-buttons.
// Each KEY pin passes through a two-flop synchroniser and an optional
// per-bit debounce filter. Press events (released -> pressed) are latched
// in a W1C edge-capture register. A level irq is raised while any
// unmasked captured bit is set.
// Build option: define KEY_PIO_DEBOUNCE_EN to include the debounce
// counters. When it is undefined, the debounced state is the
// synchroniser output.
module key_pio_irq #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  logic [WIDTH-1:0] sync1_q, sync1_d;
  logic [WIDTH-1:0] sync2_q, sync2_d;
  logic [WIDTH-1:0] stable_s;
  logic [WIDTH-1:0] stable_dly_q, stable_dly_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] edgecap_q, edgecap_d;
  logic [WIDTH-1:0] press_s;
  logic [WIDTH-1:0] clr_s;
  logic             wr_s;
  logic [31:0]      rd_s;

  // Synchroniser next state: pins shift through two flops.
  always_comb begin
    sync1_d = in_port;
    sync2_d = sync1_q;
  end

  // Synchroniser flops; reset to the released level so no press is
  // seen at reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

`ifdef KEY_PIO_DEBOUNCE_EN
  localparam int            CW      = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0]    cnt_q [WIDTH];
  logic [CW-1:0]    cnt_d [WIDTH];
  logic [WIDTH-1:0] stable_q, stable_d;

  // Debounce: count consecutive clocks the synchronised pin disagrees
  // with the accepted state; accept after DEBOUNCE_CYCLES of them.
  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      stable_d[i] = stable_q[i];
      cnt_d[i]    = cnt_q[i];
      if (sync2_q[i] == stable_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_MAX) begin
        stable_d[i] = sync2_q[i];
        cnt_d[i]    = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CW'(1);
      end
    end
  end

  // Debounce state registers; reset discards any partial count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stable_q <= '1;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      stable_q <= stable_d;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign stable_s = stable_q;
`else
  // The debounce length has no role without the filter.
  localparam int unused_debounce_p = DEBOUNCE_CYCLES;
  assign stable_s = sync2_q;
`endif

  // Writedata bits above WIDTH are ignored by design.
  logic unused_s;
  assign unused_s = ^writedata;

  // Register next state: press detect, mask write and W1C with set priority.
  always_comb begin
    wr_s         = chipselect & ~write_n;
    press_s      = stable_dly_q & ~stable_s;
    stable_dly_d = stable_s;
    if (wr_s && (address == 2'd2)) begin
      mask_d = writedata[WIDTH-1:0];
    end else begin
      mask_d = mask_q;
    end
    if (wr_s && (address == 2'd3)) begin
      clr_s = writedata[WIDTH-1:0];
    end else begin
      clr_s = '0;
    end
    edgecap_d = (edgecap_q & ~clr_s) | press_s;
  end

  // Control/status registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stable_dly_q <= '1;
      mask_q       <= '0;
      edgecap_q    <= '0;
    end else begin
      stable_dly_q <= stable_dly_d;
      mask_q       <= mask_d;
      edgecap_q    <= edgecap_d;
    end
  end

  // Zero-wait-state read mux, zero-extended to 32 bits.
  always_comb begin
    rd_s = 32'd0;
    case (address)
      2'd0:    rd_s[WIDTH-1:0] = ~stable_s;
      2'd2:    rd_s[WIDTH-1:0] = mask_q;
      2'd3:    rd_s[WIDTH-1:0] = edgecap_q;
      default: rd_s = 32'd0;
    endcase
  end

  assign readdata = rd_s;
  assign irq      = |(edgecap_q & mask_q);

endmodule

// File: tb/tb_key_pio_irq.sv
// Testbench for key_pio_irq with DEBOUNCE_CYCLES = 8. The reference model
// keeps a window of the last DEBOUNCE_CYCLES synchronised samples and
// accepts a change once the whole window disagrees with the accepted state.
`timescale 1ns/1ps
module tb_key_pio_irq;

  localparam int W = 4;
  localparam int D = 8;
`ifdef KEY_PIO_DEBOUNCE_EN
  localparam bit DEB_EN = 1'b1;
  localparam int LAT    = D + 3;
`else
  localparam bit DEB_EN = 1'b0;
  localparam int LAT    = 3;
`endif

  logic          clk;
  logic          reset_n;
  logic [1:0]    address;
  logic          chipselect;
  logic          write_n;
  logic [31:0]   writedata;
  logic [31:0]   readdata;
  logic [W-1:0]  in_port;
  logic          irq;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [W-1:0] m_s1, m_s2, m_stable, m_stable_dly, m_edgecap, m_mask;
  logic [W-1:0] m_hist [D];

  key_pio_irq #(.WIDTH(W), .DEBOUNCE_CYCLES(D)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .in_port    (in_port),
    .irq        (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    m_s1 = '1; m_s2 = '1; m_stable = '1; m_stable_dly = '1;
    m_edgecap = '0; m_mask = '0;
    for (int k = 0; k < D; k++) m_hist[k] = '1;
  endtask

  function automatic logic [31:0] exp_read(input logic [1:0] a);
    logic [31:0] r;
    r = 32'd0;
    case (a)
      2'd0:    r[W-1:0] = ~m_stable;
      2'd2:    r[W-1:0] = m_mask;
      2'd3:    r[W-1:0] = m_edgecap;
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  function automatic logic exp_irq();
    return |(m_edgecap & m_mask);
  endfunction

  // One clock: advance the model with the inputs seen at the edge, then
  // return at the following falling edge.
  task automatic step();
    logic [W-1:0] n_stable, n_edge, n_mask, clr, press;
    logic         wr, all_diff;
    @(posedge clk);
    if (reset_n) begin
      wr    = chipselect && !write_n;
      press = m_stable_dly & ~m_stable;
      clr   = (wr && address == 2'd3) ? writedata[W-1:0] : '0;
      n_edge = (m_edgecap & ~clr) | press;
      n_mask = (wr && address == 2'd2) ? writedata[W-1:0] : m_mask;
      if (DEB_EN) begin
        for (int k = D - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
        m_hist[0] = m_s2;
        for (int i = 0; i < W; i++) begin
          all_diff = 1'b1;
          for (int k = 0; k < D; k++)
            if (m_hist[k][i] == m_stable[i]) all_diff = 1'b0;
          n_stable[i] = all_diff ? ~m_stable[i] : m_stable[i];
        end
      end else begin
        n_stable = m_s1;
      end
      m_stable_dly = m_stable;
      m_stable     = n_stable;
      m_s2         = m_s1;
      m_s1         = in_port;
      m_edgecap    = n_edge;
      m_mask       = n_mask;
    end
    @(negedge clk);
  endtask

  task automatic do_write(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    step();
    write_n = 1'b1;
  endtask

  task automatic set_addr(input logic [1:0] a);
    chipselect = 1'b1; address = a;
    #1;
  endtask

  task automatic test_reset();
    in_port = 4'hF;
    reset_n = 1'b0;
    model_reset();
    step(); step(); step();
    for (int a = 0; a < 4; a++) begin
      if (a == 1) continue;
      set_addr(a[1:0]);
      checks++;
      if (readdata !== 32'd0) begin
        errors++;
        $display("FAIL reset_read addr%0d: got %h expected %h", a, readdata, 32'd0);
      end
    end
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL reset_irq: got %b expected 0", irq);
    end
    reset_n = 1'b1;
    for (int n = 0; n < 100; n++) begin
      step();
      set_addr(2'd0);
      checks++;
      if (readdata !== 32'd0) begin
        errors++;
        $display("FAIL idle_data cycle %0d: got %h expected %h", n, readdata, 32'd0);
      end
    end
  endtask

  task automatic test_press_latency();
    logic [31:0] e;
    do_write(2'd2, 32'h1);
    in_port = 4'hE;
    for (int n = 1; n <= LAT + 2; n++) begin
      step();
      set_addr(2'd3);
      e = (n >= LAT) ? 32'h1 : 32'h0;
      checks++;
      if (readdata !== e || readdata !== exp_read(2'd3)) begin
        errors++;
        $display("FAIL press_edgecap n=%0d: got %h expected %h", n, readdata, e);
      end
      checks++;
      if (irq !== e[0]) begin
        errors++;
        $display("FAIL press_irq n=%0d: got %b expected %b", n, irq, e[0]);
      end
      set_addr(2'd0);
      e = (n >= LAT - 1) ? 32'h1 : 32'h0;
      checks++;
      if (readdata !== e) begin
        errors++;
        $display("FAIL press_data n=%0d: got %h expected %h", n, readdata, e);
      end
    end
    do_write(2'd3, 32'h1);
    set_addr(2'd3);
    checks++;
    if (readdata !== 32'd0 || irq !== 1'b0) begin
      errors++;
      $display("FAIL w1c_clear: got edgecap %h irq %b expected 0 0", readdata, irq);
    end
    in_port = 4'hF;
    for (int n = 0; n < D + 6; n++) step();
    set_addr(2'd3);
    checks++;
    if (readdata !== 32'd0) begin
      errors++;
      $display("FAIL release_not_captured: got %h expected %h", readdata, 32'd0);
    end
  endtask

  task automatic test_glitch();
    logic [31:0] e;
    in_port = 4'hB;
    for (int n = 0; n < 7; n++) begin
      step();
      set_addr(2'd0);
      checks++;
      if (readdata !== exp_read(2'd0)) begin
        errors++;
        $display("FAIL glitch_data n=%0d: got %h expected %h", n, readdata, exp_read(2'd0));
      end
    end
    in_port = 4'hF;
    for (int n = 0; n < 20; n++) step();
    set_addr(2'd3);
    e = DEB_EN ? 32'h0 : 32'h4;
    checks++;
    if (readdata !== e) begin
      errors++;
      $display("FAIL glitch_edgecap: got %h expected %h", readdata, e);
    end
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL glitch_irq: got %b expected 0", irq);
    end
    set_addr(2'd0);
    checks++;
    if (readdata !== 32'd0) begin
      errors++;
      $display("FAIL glitch_data_end: got %h expected %h", readdata, 32'd0);
    end
    do_write(2'd3, 32'hF);
  endtask

  task automatic test_mask();
    do_write(2'd2, 32'h0);
    in_port = 4'hD;
    for (int n = 0; n < LAT + 2; n++) step();
    set_addr(2'd3);
    checks++;
    if (readdata !== 32'h2 || irq !== 1'b0) begin
      errors++;
      $display("FAIL masked_capture: got edgecap %h irq %b expected 2 0", readdata, irq);
    end
    do_write(2'd2, 32'h2);
    checks++;
    if (irq !== 1'b1) begin
      errors++;
      $display("FAIL unmask_irq: got %b expected 1", irq);
    end
    in_port = 4'hF;
    for (int n = 0; n < D + 4; n++) step();
    do_write(2'd3, 32'hF);
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL mask_cleanup_irq: got %b expected 0", irq);
    end
  endtask

  task automatic test_set_wins();
    in_port = 4'h7;
    for (int n = 0; n < LAT - 1; n++) step();
    set_addr(2'd3);
    checks++;
    if (readdata[3] !== 1'b0) begin
      errors++;
      $display("FAIL setwins_pre: got %b expected 0", readdata[3]);
    end
    do_write(2'd3, 32'h8);
    set_addr(2'd3);
    checks++;
    if (readdata[3] !== 1'b1 || readdata !== exp_read(2'd3)) begin
      errors++;
      $display("FAIL set_wins: got %h expected %h", readdata, exp_read(2'd3));
    end
    in_port = 4'hF;
    for (int n = 0; n < D + 4; n++) step();
    do_write(2'd3, 32'h8);
    set_addr(2'd3);
    checks++;
    if (readdata !== 32'd0) begin
      errors++;
      $display("FAIL setwins_clear: got %h expected %h", readdata, 32'd0);
    end
  endtask

  task automatic test_random();
    int hold = 0;
    logic [1:0] a;
    for (int n = 0; n < 1500; n++) begin
      if (hold == 0) begin
        in_port = W'($urandom);
        hold = $urandom_range(1, 2 * D);
      end
      hold--;
      chipselect = 1'b1;
      write_n    = ($urandom_range(0, 7) == 0) ? 1'b0 : 1'b1;
      address    = 2'($urandom);
      writedata  = $urandom;
      step();
      write_n = 1'b1;
      a = 2'($urandom);
      set_addr(a);
      checks++;
      if (readdata !== exp_read(a) || irq !== exp_irq()) begin
        errors++;
        $display("FAIL random n=%0d addr%0d: got %h irq %b expected %h irq %b",
                 n, a, readdata, irq, exp_read(a), exp_irq());
      end
    end
    in_port = 4'hF;
    for (int n = 0; n < D + 4; n++) step();
    do_write(2'd3, 32'hF);
  endtask

  task automatic test_reset_mid();
    logic [31:0] e;
    in_port = 4'hE;
    for (int n = 0; n < LAT / 2; n++) step();
    reset_n = 1'b0;
    model_reset();
    step(); step();
    reset_n = 1'b1;
    for (int n = 1; n <= LAT + 1; n++) begin
      step();
      set_addr(2'd3);
      e = (n >= LAT) ? 32'h1 : 32'h0;
      checks++;
      if (readdata !== e || readdata !== exp_read(2'd3)) begin
        errors++;
        $display("FAIL reset_mid n=%0d: got %h expected %h", n, readdata, e);
      end
    end
    in_port = 4'hF;
  endtask

  initial begin
    reset_n = 1'b0; chipselect = 1'b0; write_n = 1'b1;
    address = 2'd0; writedata = 32'd0; in_port = 4'hF;
    model_reset();
    test_reset();
    test_press_latency();
    test_glitch();
    test_mask();
    test_set_wins();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/key_pio_irq.md
# key_pio_irq

Avalon-MM slave input PIO for the board push-buttons, sitting upstream of the LED output PIO in the key-interrupt system. It synchronises and debounces the active-low KEY pins and latches press events in an edge-capture register. It raises a level interrupt to the HPS when an unmasked captured edge is pending. The Linux driver acknowledges each key event by clearing the captured edge, then writes the LED PIO.

## Interface
- WIDTH, 4, number of key inputs (1..32)
- DEBOUNCE_CYCLES, 500000, consecutive stable clocks required before an input change is accepted (10 ms at 50 MHz); must be ≥ 2
- clk  input  1  system clock
- reset_n  input  1  reset; asynchronous, active-low
- address  input  2  register select
- chipselect  input  1  slave select
- write_n  input  1  active-low write strobe
- writedata  input  32  write data; bits above WIDTH ignored
- readdata  output  32  read data; zero-extended; combinational, valid in the same cycle as address/chipselect (0 wait states)
- in_port  input  WIDTH  raw KEY pins; asynchronous; 0 = pressed
- irq  output  1  level interrupt, active-high

## Operation
- Register map:
  - addr 0, DATA (RO): current debounced state, 1 = pressed (= ~stable).
  - addr 1: reserved; reads 0, writes ignored.
  - addr 2, IRQMASK (RW): WIDTH bits.
  - addr 3, EDGECAP (R/W1C): WIDTH bits.
- Writes take effect when chipselect && !write_n, at the rising clk edge.
- Synchroniser: two flops per bit (sync1, sync2), reset to all 1s (released).
- Debounce uses one counter per bit, each ceil(log2(DEBOUNCE_CYCLES)) bits wide. Each clock:
  - If sync2[i] == stable[i], cnt[i] <= 0.
  - Otherwise cnt[i] increments.
  - When cnt[i] == DEBOUNCE_CYCLES-1 while sync2[i] still differs, stable[i] <= sync2[i] and cnt[i] <= 0.
  - Any glitch shorter than DEBOUNCE_CYCLES resets the count. The counter never wraps.
- Press detect:
  - stable_d is stable delayed one clock.
  - press[i] = stable_d[i] & ~stable[i] (1→0 transition).
  - Release transitions are not captured.
- EDGECAP:
  - Bit i sets on press[i].
  - Bit i clears when addr 3 is written with writedata[i]=1.
  - Set and clear of the same bit in the same cycle: set wins.
- irq = |(EDGECAP & IRQMASK). It is combinational from registers and has no internal glitch source.
- Reads have no side effects.

## Timing
- Reset values:
  - sync1, sync2, stable and stable_d are all 1s.
  - cnt = 0, EDGECAP = 0, IRQMASK = 0.
  - irq = 0, readdata = 0 at address 0.
- Pin-to-capture latency, for a clean press sampled at edge 0:
  - sync2 falls at edge 2.
  - stable falls at edge 2+DEBOUNCE_CYCLES.
  - EDGECAP bit and irq assert at edge 3+DEBOUNCE_CYCLES.
- DATA reads pressed from edge 2+DEBOUNCE_CYCLES.
- A W1C write at edge k clears EDGECAP, and irq deasserts after edge k unless another press is pending.
- An IRQMASK write masks or unmasks irq immediately after the write edge; captured bits are retained while masked.
- Keys are independent. Simultaneous presses on several bits capture all of them in the same cycle.
- Asynchronous reset mid-debounce discards the partial count. A key held through reset is accepted DEBOUNCE_CYCLES+2 clocks after reset release and is captured as a press.

## Configuration
- KEY_PIO_DEBOUNCE_EN defined: debounce counters are present, as specified above.
- KEY_PIO_DEBOUNCE_EN undefined:
  - No counters are instantiated and stable = sync2 directly; DEBOUNCE_CYCLES is unused.
  - Pin-to-irq latency is 3 clocks, and DATA follows sync2.
- Register map and irq behaviour are otherwise identical.

## Test plan
- Reset with in_port=4'hF:
  - readdata=0 at addr 0, 2 and 3; irq=0.
  - After release, DATA stays 0 for 100 clocks.
- DEBOUNCE_CYCLES=8, IRQMASK=4'h1, in_port[0] low:
  - EDGECAP reads 4'h1 and irq=1 exactly 11 clocks after sampling; DATA=4'h1.
  - Write 4'h1 to addr 3: EDGECAP=0, irq=0 next cycle.
- DEBOUNCE_CYCLES=8, 7-clock low pulse on in_port[2] followed by 4'hF: DATA, EDGECAP and irq stay 0.
- IRQMASK=0 with a press on bit 1:
  - EDGECAP=4'h2 and irq=0.
  - Write IRQMASK=4'h2: irq=1 the next cycle.
- Bit 3 press completes in the same cycle as a W1C write of 4'h8 to addr 3: EDGECAP[3] remains 1 (set wins).
- Reset asserted mid-count with in_port[0] held low: after release, capture occurs DEBOUNCE_CYCLES+3 clocks later. Also run this with KEY_PIO_DEBOUNCE_EN undefined: capture occurs 3 clocks after release.
